// File: rtl/controller_registers_pkg.sv
// Shared encodings for the controller register block: FSM states, register
// offsets within a controller slot, global addresses and STATUS bit positions.
package controller_registers_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  localparam logic [1:0] OFS_CUR      = 2'd0;
  localparam logic [1:0] OFS_PRESSED  = 2'd1;
  localparam logic [1:0] OFS_RELEASED = 2'd2;

  localparam logic [3:0] ADDR_STATUS = 4'hE;
  localparam logic [3:0] ADDR_FRAME  = 4'hF;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_OVERRUN_BIT = 1;

endpackage

// File: rtl/controller_edge_regs.sv
// Per-controller snapshot plus sticky pressed/released edge flags with
// clear-on-read; a capture in the same cycle as a clear wins for new bits.
module controller_edge_regs
  import controller_registers_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       capture,
  input  logic [7:0] data,
  input  logic [1:0] offset,
  input  logic       read_sel,
  output logic [7:0] rdata
);

  logic [7:0] cur;
  logic [7:0] pressed;
  logic [7:0] released;
  logic       clear_pressed;
  logic       clear_released;

  assign clear_pressed  = read_sel && (offset == OFS_PRESSED);
  assign clear_released = read_sel && (offset == OFS_RELEASED);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make cur's update visible to the
  // edge terms below within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= 8'h00;
      pressed  <= 8'h00;
      released <= 8'h00;
    end else begin
      if (capture) cur <= data;
      pressed  <= (clear_pressed  ? 8'h00 : pressed)
                | (capture ? (data & ~cur) : 8'h00);
      released <= (clear_released ? 8'h00 : released)
                | (capture ? (~data & cur) : 8'h00);
    end
  end

  // NOTE: a default assignment before the case keeps this purely
  // combinational; an uncovered path would otherwise infer a latch.
  always_comb begin
    rdata = 8'h00;
    case (offset)
      OFS_CUR:      rdata = cur;
      OFS_PRESSED:  rdata = pressed;
      OFS_RELEASED: rdata = released;
      default:      rdata = 8'h00;
    endcase
  end

endmodule

// File: rtl/controller_registers.sv
// Per-frame fetch scheduler and CPU register file for the game controllers:
// vblank-triggered fetch, fixed-latency snapshot, registered read port.
module controller_registers
  import controller_registers_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 2,
  parameter int FETCH_LATENCY   = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vblank_i,
  output logic                         start_fetch_o,
  input  logic [8*NUM_CONTROLLERS-1:0] data_LIST_i,
  input  logic [3:0]                   addr_i,
  input  logic                         read_i,
  output logic [7:0]                   rdata_o
);

  localparam int TW = (FETCH_LATENCY > 1) ? $clog2(FETCH_LATENCY) : 1;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [TW-1:0] timer;
  logic [7:0]    frame;
  logic          overrun;
  logic          capture;
  logic          overrun_set;
  logic          busy;
  logic [1:0]    slot;
  logic [1:0]    offset;
  logic [7:0]    ctrl_rdata [NUM_CONTROLLERS];
  logic [7:0]    read_mux;

  assign slot   = addr_i[3:2];
  assign offset = addr_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (vblank_i) next_state = WAIT;
      WAIT:    if (timer == '0) next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // vblank outside IDLE is dropped but recorded as an overrun.
  always_comb begin
    start_fetch_o = (state == IDLE) && vblank_i;
    capture       = (state == CAPTURE);
    overrun_set   = (state != IDLE) && vblank_i;
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (start_fetch_o) begin
      timer <= TW'(FETCH_LATENCY - 1);
    end else if (state == WAIT && timer != '0) begin
      timer <= timer - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame   <= 8'h00;
      overrun <= 1'b0;
    end else begin
      if (capture) frame <= frame + 8'd1;
      overrun <= ((read_i && addr_i == ADDR_STATUS) ? 1'b0 : overrun) | overrun_set;
    end
  end

  for (genvar k = 0; k < NUM_CONTROLLERS; k++) begin : g_ctrl
    controller_edge_regs u_regs (
      .clk      (clk),
      .rst_n    (rst_n),
      .capture  (capture),
      .data     (data_LIST_i[8*k +: 8]),
      .offset   (offset),
      .read_sel (read_i && int'(slot) == k),
      .rdata    (ctrl_rdata[k])
    );
  end

  // Slot 3 is never a controller, so STATUS/FRAME cannot alias a slot.
  always_comb begin
    read_mux = 8'h00;
    if (addr_i == ADDR_STATUS) begin
      read_mux[STATUS_BUSY_BIT]    = busy;
      read_mux[STATUS_OVERRUN_BIT] = overrun;
    end else if (addr_i == ADDR_FRAME) begin
      read_mux = frame;
    end else begin
      for (int k = 0; k < NUM_CONTROLLERS; k++) begin
        if (int'(slot) == k) read_mux = ctrl_rdata[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rdata_o <= 8'h00;
    else if (read_i) rdata_o <= read_mux;
  end

endmodule

// File: tb/tb_controller_registers.sv
// Directed bench for controller_registers (2 controllers, fetch latency 12).
module tb_controller_registers;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblank_i = 1'b0;
  logic        start_fetch_o;
  logic [15:0] data_LIST_i = 16'h0000;
  logic [3:0]  addr_i = 4'h0;
  logic        read_i = 1'b0;
  logic [7:0]  rdata_o;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int fetch_count = 0;
  int fetch_cycle = -1;
  int bad_fetch = 0;
  int vb_cycle = 0;
  int exp_fetch = 0;
  logic [7:0] rd;

  controller_registers #(.NUM_CONTROLLERS(2), .FETCH_LATENCY(12)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vblank_i      (vblank_i),
    .start_fetch_o (start_fetch_o),
    .data_LIST_i   (data_LIST_i),
    .addr_i        (addr_i),
    .read_i        (read_i),
    .rdata_o       (rdata_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (start_fetch_o) begin
      fetch_count++;
      fetch_cycle = cycle;
      if (!vblank_i) bad_fetch++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
    addr_i = a;
    read_i = 1'b1;
    @(posedge clk);
    #1;
    read_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic expect_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    read_reg(a, d);
    check(tag, {24'h0, d}, {24'h0, exp});
  endtask

  // Pulse vblank for one cycle; on return the bench is at cycle t+1.
  task automatic pulse_vblank();
    vblank_i = 1'b1;
    vb_cycle = cycle;
    @(posedge clk);
    #1;
    vblank_i = 1'b0;
  endtask

  // Accepted frame: pulse, then idle up to the first cycle the snapshot is visible.
  task automatic run_frame();
    pulse_vblank();
    exp_fetch++;
    idle(13);
  endtask

  initial begin
    idle(3);
    check("reset_rdata", {24'h0, rdata_o}, 32'h0);
    check("reset_start_fetch", {31'h0, start_fetch_o}, 32'h0);
    rst_n = 1'b1;
    idle(2);
    expect_read("rst_cur0", 4'h0, 8'h00);
    expect_read("rst_pressed0", 4'h1, 8'h00);
    expect_read("rst_status", 4'hE, 8'h00);
    expect_read("rst_frame", 4'hF, 8'h00);
    check("no_fetch_without_vblank", fetch_count, 0);

    // Frame 1: ctrl0 = A5, ctrl1 = 3C
    data_LIST_i = 16'h3CA5;
    idle(2);
    pulse_vblank();
    exp_fetch++;
    check("fetch_cycle", fetch_cycle, vb_cycle);
    check("fetch_count_f1", fetch_count, exp_fetch);
    idle(13);
    expect_read("f1_cur0", 4'h0, 8'hA5);
    expect_read("f1_pressed0", 4'h1, 8'hA5);
    expect_read("f1_released0", 4'h2, 8'h00);
    expect_read("f1_cur1", 4'h4, 8'h3C);
    expect_read("f1_pressed1", 4'h5, 8'h3C);
    expect_read("f1_reserved3", 4'h3, 8'h00);
    expect_read("f1_slot2", 4'h8, 8'h00);
    expect_read("f1_frame", 4'hF, 8'h01);
    idle(3);
    check("rdata_hold", {24'h0, rdata_o}, 32'h01);
    expect_read("f1_pressed0_cleared", 4'h1, 8'h00);

    // Frame 2: ctrl0 A5 -> 0F
    data_LIST_i = 16'h3C0F;
    run_frame();
    expect_read("f2_pressed0", 4'h1, 8'h0A);
    expect_read("f2_released0", 4'h2, 8'hA0);
    expect_read("f2_pressed0_again", 4'h1, 8'h00);
    expect_read("f2_released0_again", 4'h2, 8'h00);
    expect_read("f2_pressed1", 4'h5, 8'h00);
    expect_read("f2_cur0", 4'h0, 8'h0F);
    expect_read("f2_frame", 4'hF, 8'h02);

    // Overrun: second vblank 5 cycles into the fetch is ignored
    pulse_vblank();
    exp_fetch++;
    idle(4);
    pulse_vblank();
    check("overrun_no_fetch", fetch_count, exp_fetch);
    expect_read("status_busy_overrun", 4'hE, 8'h03);
    idle(7);
    expect_read("status_cleared", 4'hE, 8'h00);
    expect_read("f3_frame", 4'hF, 8'h03);

    // Clear-on-read colliding with a capture
    data_LIST_i = 16'h3C0E;
    run_frame();
    expect_read("fa_released0", 4'h2, 8'h01);
    data_LIST_i = 16'h3C0F;
    run_frame();
    data_LIST_i = 16'h3C8F;
    pulse_vblank();
    exp_fetch++;
    idle(12);
    expect_read("capture_read_old", 4'h1, 8'h01);
    expect_read("capture_read_new", 4'h1, 8'h80);
    expect_read("fc_cur0", 4'h0, 8'h8F);
    expect_read("fc_frame", 4'hF, 8'h06);

    // FRAME wrap
    for (int i = 0; i < 249; i++) run_frame();
    expect_read("frame_ff", 4'hF, 8'hFF);
    run_frame();
    expect_read("frame_wrap", 4'hF, 8'h00);
    check("fetch_total", fetch_count, exp_fetch);
    check("fetch_only_with_vblank", bad_fetch, 0);

    // Reset during WAIT abandons the capture
    data_LIST_i = 16'h1155;
    pulse_vblank();
    exp_fetch++;
    expect_read("pre_reset_cur0", 4'h0, 8'h8F);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    check("reset_clears_rdata", {24'h0, rdata_o}, 32'h0);
    rst_n = 1'b1;
    idle(1);
    expect_read("post_reset_status", 4'hE, 8'h00);
    idle(15);
    expect_read("post_reset_cur0", 4'h0, 8'h00);
    expect_read("post_reset_cur1", 4'h4, 8'h00);
    expect_read("post_reset_frame", 4'hF, 8'h00);
    check("post_reset_fetch_count", fetch_count, exp_fetch);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
